bpu_ras_ctrl: RTL and testbench
===============================

BPU_RAS_CTRL -- requirements
Module: bpu_ras_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of PC and return targets.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  fetch-side control-flow request valid.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when req_valid_i & req_ready_o.
REQ-006 SHALL have port req_pc_i  input  ADDR_WIDTH  PC of the call/return instruction.
REQ-007 SHALL have port req_call_i  input  1  instruction is a call (link write).
REQ-008 SHALL have port req_ret_i  input  1  instruction is a return (link read).
REQ-009 SHALL have port req_rvc_i  input  1  instruction is 16-bit compressed.
REQ-010 SHALL have port pred_valid_o  output  1  return prediction beat valid.
REQ-011 SHALL have port pred_ready_i  input  1  consumer accepts prediction beat.
REQ-012 SHALL have port pred_target_o  output  ADDR_WIDTH  predicted return address.
REQ-013 SHALL have port pred_hit_o  output  1  prediction came from a non-empty stack.
REQ-014 SHALL have port flush_i  input  1  pipeline flush/redirect.
REQ-015 SHALL have port ras_push_o  output  1  push strobe to return stack.
REQ-016 SHALL have port ras_pdata_o  output  ADDR_WIDTH  link address to push.
REQ-017 SHALL have port ras_pop_o  output  1  pop strobe to return stack.
REQ-018 SHALL have ports ras_rdata_i (ADDR_WIDTH), ras_empty_i (1), ras_full_i (1), inputs, stack top-of-stack data and status.
REQ-019 SHALL have port ovf_o  output  1  one-cycle pulse: push issued while stack full.

Function
REQ-020 SHALL implement FSM states IDLE and PUSH_PEND; reset state IDLE.
REQ-021 SHALL drive req_ready_o = (state==IDLE) & ~flush_i & (~pred_valid_o | pred_ready_i).
REQ-022 SHALL compute link = req_pc_i + (req_rvc_i ? 2 : 4), modulo 2^ADDR_WIDTH (wrap, no carry out).
REQ-023 Call only: on accept SHALL assert ras_push_o and ras_pdata_o=link combinationally in the accept cycle; no prediction beat.
REQ-024 Return only: on accept SHALL load pred_target_o=ras_rdata_i, pred_hit_o=~ras_empty_i, set pred_valid_o next cycle (latency 1); SHALL assert ras_pop_o in accept cycle only if ~ras_empty_i.
REQ-025 Return with empty stack: SHALL output pred_target_o=0, pred_hit_o=0, no pop.
REQ-026 Call and return together: accept cycle SHALL behave as REQ-024, capture link in a pending register, go to PUSH_PEND; next cycle SHALL assert ras_push_o with pending link and return to IDLE; never push and pop in the same cycle.
REQ-027 Neither call nor return: request SHALL be accepted and consumed with no stack or prediction activity.
REQ-028 pred_valid_o SHALL hold with target/hit stable until pred_ready_i; beat retires on pred_valid_o & pred_ready_i; a new beat may load the same cycle (back-to-back).
REQ-029 flush_i SHALL, same cycle, force ras_push_o=0, ras_pop_o=0, req_ready_o=0; next cycle pred_valid_o=0 and state=IDLE, pending link dropped.
REQ-030 ovf_o SHALL pulse 1 cycle after any ras_push_o issued while ras_full_i=1; push still issued (stack overwrites oldest).
REQ-031 Outside accept/PUSH_PEND cycles ras_push_o and ras_pop_o SHALL be 0; ras_pdata_o is don't-care when ras_push_o=0.

Reset
REQ-032 On rst_n_i low SHALL asynchronously set state=IDLE, pred_valid_o=0, pred_target_o=0, pred_hit_o=0, pending link=0, ovf_o=0.
REQ-033 Reset mid-PUSH_PEND SHALL discard the pending push; no push strobe after release.
REQ-034 After reset release req_ready_o SHALL be 1 (flush_i=0) in the first cycle.

Verification
REQ-035 Call pc=0x1000 rvc=0, then return (stack model top=0x1004) -> push 0x1004 in cycle 0; pop, pred_target_o=0x1004, pred_hit_o=1 valid cycle after return accept.
REQ-036 Return with ras_empty_i=1 -> no pop, pred_valid_o=1, pred_target_o=0, pred_hit_o=0.
REQ-037 Call+return pc=0x2000 rvc=1, top=0x3000 -> cycle0 pop, pred 0x3000; cycle1 push 0x2002, req_ready_o=0; cycle2 IDLE.
REQ-038 pred_ready_i=0 for 3 cycles with pending beat -> req_ready_o=0, outputs stable; ready=1 -> beat retires, next request accepted same cycle.
REQ-039 flush_i asserted during PUSH_PEND -> no push, pred_valid_o=0 next cycle, state IDLE.
REQ-040 Call pc=0xFFFFFFFC rvc=0 with ras_full_i=1 -> ras_pdata_o=0x00000000, push issued, ovf_o=1 for exactly one cycle.

Source files
------------

// File: rtl/bpu_ras_ctrl.sv
// ---------------------------------------------------------------------------
// bpu_ras_ctrl
//   Control block between the fetch-side branch predictor and a return
//   address stack (RAS). Calls push their link address (pc+2 or pc+4),
//   returns pop the top of stack and present it as a one-beat prediction.
//   A combined call+return (e.g. a co-routine swap) pops in the accept cycle
//   and pushes the captured link in the following cycle, so the stack never
//   sees a push and a pop together.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_valid_i/ready_o   control-flow request handshake
//   req_pc_i              PC of the call/return instruction
//   req_call_i/ret_i      instruction class (both may be set)
//   req_rvc_i             16-bit compressed encoding (link = pc+2)
//   pred_valid_o/ready_i  return prediction handshake
//   pred_target_o/hit_o   predicted target, and whether the stack was non-empty
//   flush_i               pipeline redirect; cancels everything in flight
//   ras_push_o/pdata_o    push strobe and link data to the stack
//   ras_pop_o             pop strobe to the stack
//   ras_rdata_i           stack top-of-stack data
//   ras_empty_i/full_i    stack status
//   ovf_o                 one-cycle pulse after a push into a full stack
// ---------------------------------------------------------------------------
module bpu_ras_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_pc_i,
   input  logic                  req_call_i,
   input  logic                  req_ret_i,
   input  logic                  req_rvc_i,
   output logic                  pred_valid_o,
   input  logic                  pred_ready_i,
   output logic [ADDR_WIDTH-1:0] pred_target_o,
   output logic                  pred_hit_o,
   input  logic                  flush_i,
   output logic                  ras_push_o,
   output logic [ADDR_WIDTH-1:0] ras_pdata_o,
   output logic                  ras_pop_o,
   input  logic [ADDR_WIDTH-1:0] ras_rdata_i,
   input  logic                  ras_empty_i,
   input  logic                  ras_full_i,
   output logic                  ovf_o
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      PUSH_PEND = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] STEP_RVC = ADDR_WIDTH'(3'd2);
   localparam logic [ADDR_WIDTH-1:0] STEP_STD = ADDR_WIDTH'(3'd4);
   localparam logic [ADDR_WIDTH-1:0] ZERO     = {ADDR_WIDTH{1'b0}};

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic                    pred_valid_r;
   logic [ADDR_WIDTH-1:0]   pred_target_r;
   logic                    pred_hit_r;
   logic [ADDR_WIDTH-1:0]   pend_link_r;
   logic                    ovf_r;

   logic                    ready_s;
   logic                    accept_s;
   logic                    call_ret_s;
   logic [ADDR_WIDTH-1:0]   link_s;
   logic                    push_s;
   logic                    pop_s;
   logic [ADDR_WIDTH-1:0]   pdata_s;

   // A request is only taken when no push is pending, no flush is active and
   // the prediction slot is free or retiring this cycle (back-to-back beats).
   assign ready_s    = (state_r == IDLE) & ~flush_i & (~pred_valid_r | pred_ready_i);
   assign accept_s   = req_valid_i & ready_s;
   assign call_ret_s = req_call_i & req_ret_i;

   // Link address wraps at 2^ADDR_WIDTH; the carry out is intentionally lost.
   assign link_s = req_pc_i + (req_rvc_i ? STEP_RVC : STEP_STD);

   // Stack strobes and FSM next state.
   always_comb begin
      push_s      = 1'b0;
      pop_s       = 1'b0;
      pdata_s     = link_s;
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               // A combined call+return defers its push by one cycle.
               push_s = req_call_i & ~req_ret_i;
               pop_s  = req_ret_i & ~ras_empty_i;
               if (call_ret_s) begin
                  state_nxt_s = PUSH_PEND;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PUSH_PEND: begin
            // Flush drops the deferred push; accept_s is already low here.
            push_s      = ~flush_i;
            pdata_s     = pend_link_r;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Deferred link for call+return; cleared by flush so nothing stale survives.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_link_r <= ZERO;
      end else if (flush_i) begin
         pend_link_r <= ZERO;
      end else if (accept_s && call_ret_s) begin
         pend_link_r <= link_s;
      end
   end

   // Prediction beat: a new return load has priority over retirement, which
   // lets a retiring beat be replaced in the same cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pred_valid_r  <= 1'b0;
         pred_target_r <= ZERO;
         pred_hit_r    <= 1'b0;
      end else if (flush_i) begin
         pred_valid_r  <= 1'b0;
      end else if (accept_s && req_ret_i) begin
         pred_valid_r  <= 1'b1;
         pred_target_r <= ras_empty_i ? ZERO : ras_rdata_i;
         pred_hit_r    <= ~ras_empty_i;
      end else if (pred_valid_r && pred_ready_i) begin
         pred_valid_r  <= 1'b0;
      end
   end

   // Overflow pulse one cycle after a push into a full stack.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= push_s & ras_full_i;
      end
   end

   assign req_ready_o   = ready_s;
   assign ras_push_o    = push_s;
   assign ras_pop_o     = pop_s;
   assign ras_pdata_o   = pdata_s;
   assign pred_valid_o  = pred_valid_r;
   assign pred_target_o = pred_target_r;
   assign pred_hit_o    = pred_hit_r;
   assign ovf_o         = ovf_r;

endmodule

// File: tb/tb_bpu_ras_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bpu_ras_ctrl
//   Directed, table-driven bench for bpu_ras_ctrl. Each table row is one
//   clock cycle: inputs are driven on the falling edge, combinational
//   outputs are checked shortly after, and registered outputs are checked
//   just after the following rising edge. Rows form one continuous
//   sequence from reset. Reset behaviour is checked by hand-written steps.
// ---------------------------------------------------------------------------
module tb_bpu_ras_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_pc_i;
   logic        req_call_i;
   logic        req_ret_i;
   logic        req_rvc_i;
   logic        pred_valid_o;
   logic        pred_ready_i;
   logic [31:0] pred_target_o;
   logic        pred_hit_o;
   logic        flush_i;
   logic        ras_push_o;
   logic [31:0] ras_pdata_o;
   logic        ras_pop_o;
   logic [31:0] ras_rdata_i;
   logic        ras_empty_i;
   logic        ras_full_i;
   logic        ovf_o;

   int tests = 0;
   int fails = 0;

   bpu_ras_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_pc_i(req_pc_i), .req_call_i(req_call_i), .req_ret_i(req_ret_i),
      .req_rvc_i(req_rvc_i),
      .pred_valid_o(pred_valid_o), .pred_ready_i(pred_ready_i),
      .pred_target_o(pred_target_o), .pred_hit_o(pred_hit_o),
      .flush_i(flush_i),
      .ras_push_o(ras_push_o), .ras_pdata_o(ras_pdata_o), .ras_pop_o(ras_pop_o),
      .ras_rdata_i(ras_rdata_i), .ras_empty_i(ras_empty_i), .ras_full_i(ras_full_i),
      .ovf_o(ovf_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        call;
      logic        ret;
      logic        rvc;
      logic        prdy;
      logic        fl;
      logic [31:0] rdata;
      logic        empty;
      logic        full;
      logic        e_ready;
      logic        e_push;
      logic [31:0] e_pdata;
      logic        e_pop;
      logic        e_pv;
      logic [31:0] e_tgt;
      logic        e_hit;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic [31:0] pc, input logic call,
                      input logic ret, input logic rvc, input logic prdy,
                      input logic fl, input logic [31:0] rdata, input logic empty,
                      input logic full, input logic e_ready, input logic e_push,
                      input logic [31:0] e_pdata, input logic e_pop, input logic e_pv,
                      input logic [31:0] e_tgt, input logic e_hit, input logic e_ovf);
      vec_t t;
      t.v = v; t.pc = pc; t.call = call; t.ret = ret; t.rvc = rvc;
      t.prdy = prdy; t.fl = fl; t.rdata = rdata; t.empty = empty; t.full = full;
      t.e_ready = e_ready; t.e_push = e_push; t.e_pdata = e_pdata; t.e_pop = e_pop;
      t.e_pv = e_pv; t.e_tgt = e_tgt; t.e_hit = e_hit; t.e_ovf = e_ovf;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic call,
                        input logic ret, input logic rvc, input logic prdy,
                        input logic fl, input logic [31:0] rdata, input logic empty,
                        input logic full);
      req_valid_i = v; req_pc_i = pc; req_call_i = call; req_ret_i = ret;
      req_rvc_i = rvc; pred_ready_i = prdy; flush_i = fl;
      ras_rdata_i = rdata; ras_empty_i = empty; ras_full_i = full;
   endtask

   initial begin
      // Columns: v, pc, call, ret, rvc, prdy, flush, rdata, empty, full |
      //          ready, push, pdata, pop | (after edge) pv, target, hit, ovf
      // Call 0x1000 pushes 0x1004, then return pops it.
      add(1, 32'h1000, 1, 0, 0, 0, 0, 32'h0,        1, 0,  1, 1, 32'h1004, 0,  0, 32'h0,        0, 0);
      add(1, 32'h1010, 0, 1, 0, 0, 0, 32'h1004,     0, 0,  1, 0, 32'h0,    1,  1, 32'h1004,     1, 0);
      add(0, 32'h0,    0, 0, 0, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,    0,  1, 32'h1004,     1, 0);
      add(0, 32'h0,    0, 0, 0, 1, 0, 32'h0,        0, 0,  1, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      // Return on empty stack: no pop, miss prediction with target 0.
      add(1, 32'h1020, 0, 1, 0, 1, 0, 32'hDEAD,     1, 0,  1, 0, 32'h0,    0,  1, 32'h0,        0, 0);
      // Three stalled cycles, then retire and accept in the same cycle.
      add(1, 32'h5000, 1, 0, 0, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,    0,  1, 32'h0,        0, 0);
      add(1, 32'h5000, 1, 0, 0, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,    0,  1, 32'h0,        0, 0);
      add(1, 32'h5000, 1, 0, 0, 0, 0, 32'h0,        0, 0,  0, 0, 32'h0,    0,  1, 32'h0,        0, 0);
      add(1, 32'h5000, 1, 0, 0, 1, 0, 32'h0,        0, 0,  1, 1, 32'h5004, 0,  0, 32'h0,        0, 0);
      // Call+return, rvc: pop now, push 0x2002 next cycle, then IDLE.
      add(1, 32'h2000, 1, 1, 1, 1, 0, 32'h3000,     0, 0,  1, 0, 32'h0,    1,  1, 32'h3000,     1, 0);
      add(1, 32'h2100, 0, 1, 0, 0, 0, 32'h7777,     0, 0,  0, 1, 32'h2002, 0,  1, 32'h3000,     1, 0);
      add(0, 32'h0,    0, 0, 0, 1, 0, 32'h0,        0, 0,  1, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      // Call+return followed by flush in PUSH_PEND: push dropped.
      add(1, 32'h4000, 1, 1, 0, 1, 0, 32'h4444,     0, 0,  1, 0, 32'h0,    1,  1, 32'h4444,     1, 0);
      add(1, 32'h4100, 1, 0, 0, 0, 1, 32'h0,        0, 0,  0, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      add(0, 32'h0,    0, 0, 0, 0, 0, 32'h0,        0, 0,  1, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      // Plain instruction: consumed with no activity.
      add(1, 32'h100,  0, 0, 0, 0, 0, 32'h5555,     0, 0,  1, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      // Wrapping link into a full stack: overflow pulse for one cycle.
      add(1, 32'hFFFFFFFC, 1, 0, 0, 0, 0, 32'h0,    0, 1,  1, 1, 32'h0,    0,  0, 32'h0,        0, 1);
      add(0, 32'h0,    0, 0, 0, 0, 0, 32'h0,        0, 1,  1, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      add(1, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 32'h0,    0, 0,  1, 1, 32'h1,    0,  0, 32'h0,        0, 0);
      // Flush blocks a return in IDLE.
      add(1, 32'h300,  0, 1, 0, 0, 1, 32'h6666,     0, 0,  0, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      // Back-to-back prediction beats.
      add(1, 32'h400,  0, 1, 0, 0, 0, 32'hAAAA0000, 0, 0,  1, 0, 32'h0,    1,  1, 32'hAAAA0000, 1, 0);
      add(1, 32'h404,  0, 1, 0, 1, 0, 32'hBBBB0000, 0, 0,  1, 0, 32'h0,    1,  1, 32'hBBBB0000, 1, 0);
      add(0, 32'h0,    0, 0, 0, 1, 0, 32'h0,        0, 0,  1, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      // Flush kills a waiting beat.
      add(1, 32'h500,  0, 1, 0, 0, 0, 32'h1234,     0, 0,  1, 0, 32'h0,    1,  1, 32'h1234,     1, 0);
      add(0, 32'h0,    0, 0, 0, 0, 1, 32'h0,        0, 0,  0, 0, 32'h0,    0,  0, 32'h0,        0, 0);
      // Deferred push into a full stack also flags overflow.
      add(1, 32'h800,  1, 1, 0, 1, 0, 32'h900,      0, 1,  1, 0, 32'h0,    1,  1, 32'h900,      1, 0);
      add(0, 32'h0,    0, 0, 0, 1, 0, 32'h0,        0, 1,  0, 1, 32'h804,  0,  0, 32'h0,        0, 1);
      add(0, 32'h0,    0, 0, 0, 1, 0, 32'h0,        0, 1,  1, 0, 32'h0,    0,  0, 32'h0,        0, 0);

      // Reset: registered outputs cleared while held.
      rst_n_i = 1'b0;
      drive(0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_pred_valid", {31'd0, pred_valid_o}, 32'd0);
      chk("rst_pred_target", pred_target_o, 32'd0);
      chk("rst_pred_hit", {31'd0, pred_hit_o}, 32'd0);
      chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("rst_ready_first", {31'd0, req_ready_o}, 32'd1);
      chk("rst_push", {31'd0, ras_push_o}, 32'd0);
      chk("rst_pop", {31'd0, ras_pop_o}, 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk_i);
         drive(vecs[i].v, vecs[i].pc, vecs[i].call, vecs[i].ret, vecs[i].rvc,
               vecs[i].prdy, vecs[i].fl, vecs[i].rdata, vecs[i].empty, vecs[i].full);
         #1;
         chk($sformatf("v%0d_ready", i), {31'd0, req_ready_o}, {31'd0, vecs[i].e_ready});
         chk($sformatf("v%0d_push", i), {31'd0, ras_push_o}, {31'd0, vecs[i].e_push});
         chk($sformatf("v%0d_pop", i), {31'd0, ras_pop_o}, {31'd0, vecs[i].e_pop});
         if (vecs[i].e_push) begin
            chk($sformatf("v%0d_pdata", i), ras_pdata_o, vecs[i].e_pdata);
         end
         @(posedge clk_i);
         #1;
         chk($sformatf("v%0d_pred_valid", i), {31'd0, pred_valid_o}, {31'd0, vecs[i].e_pv});
         if (vecs[i].e_pv) begin
            chk($sformatf("v%0d_pred_target", i), pred_target_o, vecs[i].e_tgt);
            chk($sformatf("v%0d_pred_hit", i), {31'd0, pred_hit_o}, {31'd0, vecs[i].e_hit});
         end
         chk($sformatf("v%0d_ovf", i), {31'd0, ovf_o}, {31'd0, vecs[i].e_ovf});
      end

      // Reset in the middle of PUSH_PEND discards the deferred push.
      @(negedge clk_i);
      drive(1, 32'h6000, 1, 1, 0, 1, 0, 32'h9000, 0, 0);
      @(posedge clk_i);
      #1;
      chk("pp_pred_valid", {31'd0, pred_valid_o}, 32'd1);
      drive(0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
      #1;
      chk("pp_push_pending", {31'd0, ras_push_o}, 32'd1);
      chk("pp_pdata", ras_pdata_o, 32'h6004);
      rst_n_i = 1'b0;
      #1;
      chk("pp_rst_push", {31'd0, ras_push_o}, 32'd0);
      chk("pp_rst_pred_valid", {31'd0, pred_valid_o}, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("pp_rel_push", {31'd0, ras_push_o}, 32'd0);
      chk("pp_rel_ready", {31'd0, req_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
      chk("pp_rel_push_next", {31'd0, ras_push_o}, 32'd0);
      chk("pp_rel_ovf", {31'd0, ovf_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
